// File: rtl/polyphase_pkg.sv
// Shared constants, types, coefficient table and output rounding for the polyphase MAC.
package polyphase_pkg;

  localparam int DWIDTH         = 16;
  localparam int DDWIDTH        = 2 * DWIDTH;
  localparam int AWIDTH         = DDWIDTH + 2;
  localparam int L              = 160;
  localparam int L_LOG          = 8;
  localparam int M              = 147;
  localparam int CWIDTH         = 4 * L;
  localparam int NR_STREAMS     = 16;
  localparam int NR_STREAMS_LOG = 4;
  localparam int NR_TAPS        = 4;
  localparam int CIDX_W         = L_LOG + 2;
  localparam int FRAC_BITS      = DWIDTH - 1;
  localparam int SHF_W          = AWIDTH - FRAC_BITS;

  typedef logic signed [DWIDTH-1:0]  sample_t;
  typedef logic signed [DDWIDTH-1:0] prod_t;
  typedef logic signed [AWIDTH-1:0]  acc_t;
  typedef logic [CWIDTH-1:0][DWIDTH-1:0] coef_table_t;

  localparam acc_t    ROUND_BIAS = acc_t'(1 << (FRAC_BITS - 1));
  localparam sample_t SAMPLE_MAX = 16'sh7fff;
  localparam sample_t SAMPLE_MIN = 16'sh8000;
  localparam logic signed [SHF_W-1:0] SAT_MAX = SHF_W'(SAMPLE_MAX);
  localparam logic signed [SHF_W-1:0] SAT_MIN = SHF_W'(SAMPLE_MIN);

  // Phase 0 is a pure half-gain impulse, phase M is full-scale on every tap; the rest are small fill values.
  function automatic coef_table_t build_coef();
    coef_table_t       t;
    logic [CIDX_W-1:0] idx;
    t = '0;
    for (int p = 0; p < L; p++) begin
      for (int k = 0; k < NR_TAPS; k++) begin
        idx = CIDX_W'(NR_TAPS * p + k);
        if (p == 0)
          t[idx] = (k == 0) ? 16'h4000 : 16'h0000;
        else if (p == M)
          t[idx] = 16'h7fff;
        else
          t[idx] = DWIDTH'(((p * 53 + k * 97 + 7) % 2048) - 1024);
      end
    end
    return t;
  endfunction

  localparam coef_table_t COEF = build_coef();

  function automatic sample_t sat_round(input acc_t acc);
    acc_t                    rnd;
    logic signed [SHF_W-1:0] shf;
    rnd = acc + ROUND_BIAS;
    shf = rnd[AWIDTH-1:FRAC_BITS];
    if (shf > SAT_MAX)
      return SAMPLE_MAX;
    else if (shf < SAT_MIN)
      return SAMPLE_MIN;
    else
      return sample_t'(shf);
  endfunction

endpackage

// File: rtl/coef_rom.sv
// Combinational coefficient lookup: one phase index selects its 4 taps' coefficients.
module coef_rom
  import polyphase_pkg::*;
(
  input  logic [L_LOG-1:0] phase,
  output sample_t          coef [NR_TAPS]
);

  logic [CIDX_W-1:0] base;

  assign base = {phase, 2'b00};

  always_comb begin
    for (int k = 0; k < NR_TAPS; k++) begin
      coef[k] = '0;
      if (phase < L_LOG'(L))
        coef[k] = sample_t'(COEF[base + CIDX_W'(k)]);
    end
  end

endmodule

// File: rtl/polyphase_mac.sv
// Two-stage 4-tap polyphase MAC with req/ack on both sides; phase steps by M each frame of streams.
module polyphase_mac
  import polyphase_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              req_in,
  output logic              ack_in,
  input  logic [DWIDTH-1:0] data_in_0,
  input  logic [DWIDTH-1:0] data_in_1,
  input  logic [DWIDTH-1:0] data_in_2,
  input  logic [DWIDTH-1:0] data_in_3,
  output logic              req_out,
  input  logic              ack_out,
  output logic [DWIDTH-1:0] data_out
);

  localparam int PW = L_LOG + 1;

  logic [L_LOG-1:0]          phase;
  logic [L_LOG-1:0]          phase_next;
  logic [PW-1:0]             phase_sum;
  logic [NR_STREAMS_LOG-1:0] stream_cnt;
  logic                      s1_full;
  prod_t                     s1_prod [NR_TAPS];
  sample_t                   taps    [NR_TAPS];
  sample_t                   coef    [NR_TAPS];
  acc_t                      acc_sum;
  logic                      advance;
  logic                      in_xfer;

  assign taps[0] = sample_t'(data_in_0);
  assign taps[1] = sample_t'(data_in_1);
  assign taps[2] = sample_t'(data_in_2);
  assign taps[3] = sample_t'(data_in_3);

  coef_rom u_coef_rom (
    .phase (phase),
    .coef  (coef)
  );

  // S1 may take a new group whenever its current one is leaving this cycle.
  assign advance = !req_out || ack_out;
  assign ack_in  = rst && (!s1_full || advance);
  assign in_xfer = req_in && ack_in;

  assign phase_sum  = {1'b0, phase} + PW'(M);
  assign phase_next = (phase_sum >= PW'(L)) ? L_LOG'(phase_sum - PW'(L)) : phase_sum[L_LOG-1:0];

  always_comb begin
    acc_sum = '0;
    for (int k = 0; k < NR_TAPS; k++)
      acc_sum = acc_sum + acc_t'(s1_prod[k]);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      phase      <= '0;
      stream_cnt <= '0;
      s1_full    <= 1'b0;
      req_out    <= 1'b0;
      data_out   <= '0;
      for (int k = 0; k < NR_TAPS; k++)
        s1_prod[k] <= '0;
    end else begin
      if (advance) begin
        req_out <= s1_full;
        if (s1_full)
          data_out <= sat_round(acc_sum);
      end

      if (in_xfer) begin
        s1_full <= 1'b1;
        for (int k = 0; k < NR_TAPS; k++)
          s1_prod[k] <= prod_t'(taps[k]) * prod_t'(coef[k]);
        stream_cnt <= stream_cnt + NR_STREAMS_LOG'(1);
        if (stream_cnt == NR_STREAMS_LOG'(NR_STREAMS - 1))
          phase <= phase_next;
      end else if (advance) begin
        s1_full <= 1'b0;
      end
    end
  end

endmodule
